// File: rtl/pc_gen_ras_pkg.sv
// Shared definitions for the fetch-stage PC generator: op encodings, the trap-select bit and
// the default address width.
package pc_gen_ras_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // A trap is CLEAR with this bit of pc_write_data set; the op field has no spare code.
    localparam int unsigned TRAP_SEL_BIT = 0;

    typedef enum logic [2:0] {
        PC_HOLD  = 3'd0,
        PC_ADD4  = 3'd1,
        PC_ADDI  = 3'd2,
        PC_SETI  = 3'd3,
        PC_CLEAR = 3'd4,
        PC_CALL  = 3'd5,
        PC_CALLI = 3'd6,
        PC_RET   = 3'd7
    } pc_op_e;

endpackage

// File: rtl/pc_gen_ras_ras_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry and the
// count saturates at DEPTH.
module pc_gen_ras_ras_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PW'(1);
            if (!o_full) r_count <= r_count + CW'(1);
        end else if (i_pop) begin
            r_ptr <= r_ptr - PW'(1);
            if (!o_empty) r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_ptr] <= i_data;
    end

    assign o_top   = r_mem[r_ptr - PW'(1)];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pc_gen_ras.sv
// Fetch-stage program-counter generator with trap/reset vectors, stall, call/return via a
// return-address stack, and registered misalignment/underflow pulses.
module pc_gen_ras
    import pc_gen_ras_pkg::*;
#(
    parameter int unsigned      XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = 'h100,
    parameter int unsigned      RAS_DEPTH    = 4,
    parameter int unsigned      INSN_BYTES   = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc_read_data,
    input  logic            pc_write_enable,
    input  logic            stall,
    input  logic [2:0]      pc_op,
    input  logic [XLEN-1:0] pc_write_data,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_overflow,
    output logic            ras_underflow,
    output logic            misalign_err
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(1);

    logic [XLEN-1:0] r_pc;
    logic            r_ovf, r_ufl, r_mis;

    logic [XLEN-1:0] w_nt, w_seq, w_ras_top;
    logic [CW-1:0]   w_count;
    logic            w_exempt, w_push_req, w_pop_req, w_ufl, w_mis, w_upd;
    logic            w_push, w_pop, w_full, w_empty;

    assign w_seq = r_pc + XLEN'(INSN_BYTES);

    always_comb begin
        w_nt       = r_pc;
        w_exempt   = 1'b0;
        w_push_req = 1'b0;
        w_pop_req  = 1'b0;
        w_ufl      = 1'b0;
        case (pc_op_e'(pc_op))
            PC_HOLD: w_nt = r_pc;
            PC_ADD4: w_nt = w_seq;
            PC_ADDI: w_nt = r_pc + pc_write_data;
            PC_SETI: w_nt = pc_write_data & ALIGN_MASK;
            PC_CLEAR: begin
                w_nt     = pc_write_data[TRAP_SEL_BIT] ? TRAP_VECTOR : RESET_VECTOR;
                w_exempt = 1'b1;
            end
            PC_CALL: begin
                w_nt       = r_pc + pc_write_data;
                w_push_req = 1'b1;
            end
            PC_CALLI: begin
                w_nt       = pc_write_data & ALIGN_MASK;
                w_push_req = 1'b1;
            end
            PC_RET: begin
                if (w_count == '0) begin
                    w_nt  = pc_write_data & ALIGN_MASK;
                    w_ufl = 1'b1;
                end else begin
                    w_nt      = w_ras_top;
                    w_pop_req = 1'b1;
                end
            end
            default: w_nt = r_pc;
        endcase
    end

    assign w_mis  = !w_exempt && (w_nt[1:0] != 2'b00);
    assign w_upd  = pc_write_enable && !stall;
    // A rejected (misaligned) target must leave the stack untouched as well as the PC.
    assign w_push = w_upd && w_push_req && !w_mis;
    assign w_pop  = w_upd && w_pop_req && !w_mis;

    pc_gen_ras_ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_seq),
        .o_top   (w_ras_top),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= RESET_VECTOR;
            r_ovf <= 1'b0;
            r_ufl <= 1'b0;
            r_mis <= 1'b0;
        end else begin
            r_ufl <= w_upd && w_ufl;
            r_mis <= w_upd && w_mis;
            if (w_upd && !w_mis) r_pc <= w_nt;
            if (w_push && w_full) r_ovf <= 1'b1;
        end
    end

    assign pc_read_data  = r_pc;
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_ufl;
    assign misalign_err  = r_mis;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras: expected state is queued as each step is driven and compared
// one time unit after the updating clock edge.
module tb_pc_gen_ras;

    logic        clk;
    logic        reset;
    logic [31:0] pc_read_data;
    logic        pc_write_enable;
    logic        stall;
    logic [2:0]  pc_op;
    logic [31:0] pc_write_data;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow, misalign_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        ufl;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    pc_gen_ras dut (
        .clk             (clk),
        .reset           (reset),
        .pc_read_data    (pc_read_data),
        .pc_write_enable (pc_write_enable),
        .stall           (stall),
        .pc_op           (pc_op),
        .pc_write_data   (pc_write_data),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .ras_overflow    (ras_overflow),
        .ras_underflow   (ras_underflow),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_s(input string tag, input logic [31:0] pc, input logic e,
                            input logic f, input logic o, input logic u, input logic m);
        exp_t x;
        x.tag = tag; x.pc = pc; x.empty = e; x.full = f; x.ovf = o; x.ufl = u; x.mis = m;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_underrun observed=empty expected=entry");
            return;
        end
        x = sb.pop_front();
        cmp({x.tag, ".pc"}, pc_read_data, x.pc);
        cmp({x.tag, ".empty"}, 32'(ras_empty), 32'(x.empty));
        cmp({x.tag, ".full"}, 32'(ras_full), 32'(x.full));
        cmp({x.tag, ".ovf"}, 32'(ras_overflow), 32'(x.ovf));
        cmp({x.tag, ".ufl"}, 32'(ras_underflow), 32'(x.ufl));
        cmp({x.tag, ".mis"}, 32'(misalign_err), 32'(x.mis));
    endtask

    // Drive one op for a cycle, queue the expected post-edge state, then compare.
    task automatic step(input string tag, input logic [2:0] op, input logic [31:0] data,
                        input logic st, input logic [31:0] pc, input logic e, input logic f,
                        input logic o, input logic u, input logic m);
        @(negedge clk);
        pc_write_enable = 1'b1;
        stall           = st;
        pc_op           = op;
        pc_write_data   = data;
        expect_s(tag, pc, e, f, o, u, m);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        reset           = 1'b0;
        pc_write_enable = 1'b0;
        stall           = 1'b0;
        pc_op           = 3'd0;
        pc_write_data   = '0;
        #12;
        expect_s("reset", 32'h0, 1, 0, 0, 0, 0);
        check_out();
        @(negedge clk);
        reset = 1'b1;

        // Sequential fetch with a stall on the second cycle
        step("add4_a",  3'd1, 0, 0, 32'h4, 1, 0, 0, 0, 0);
        step("add4_st", 3'd1, 0, 1, 32'h4, 1, 0, 0, 0, 0);
        step("add4_b",  3'd1, 0, 0, 32'h8, 1, 0, 0, 0, 0);
        step("add4_c",  3'd1, 0, 0, 32'hC, 1, 0, 0, 0, 0);

        // Call / return pair
        step("seti10",  3'd3, 32'h10,  0, 32'h10,  1, 0, 0, 0, 0);
        step("call",    3'd5, 32'h100, 0, 32'h110, 0, 0, 0, 0, 0);
        step("ret",     3'd7, 32'h0,   0, 32'h14,  1, 0, 0, 0, 0);

        // Five calls overflow a 4-deep stack; the oldest return (0x18) is lost
        step("call1",   3'd5, 32'h100, 0, 32'h114, 0, 0, 0, 0, 0);
        step("call2",   3'd5, 32'h100, 0, 32'h214, 0, 0, 0, 0, 0);
        step("call3",   3'd5, 32'h100, 0, 32'h314, 0, 0, 0, 0, 0);
        step("call4",   3'd5, 32'h100, 0, 32'h414, 0, 1, 0, 0, 0);
        step("call5",   3'd5, 32'h100, 0, 32'h514, 0, 1, 1, 0, 0);
        step("ret1",    3'd7, 32'h0,   0, 32'h418, 0, 0, 1, 0, 0);
        step("ret2",    3'd7, 32'h0,   0, 32'h318, 0, 0, 1, 0, 0);
        step("ret3",    3'd7, 32'h0,   0, 32'h218, 0, 0, 1, 0, 0);
        step("ret4",    3'd7, 32'h0,   0, 32'h118, 1, 0, 1, 0, 0);
        step("ret_ufl", 3'd7, 32'h2001, 0, 32'h2000, 1, 0, 1, 1, 0);
        step("ufl_clr", 3'd0, 32'h0,   0, 32'h2000, 1, 0, 1, 0, 0);

        // Misaligned targets are rejected, including a call (no push)
        step("seti20",  3'd3, 32'h20, 0, 32'h20, 1, 0, 1, 0, 0);
        step("addi2",   3'd2, 32'h2,  0, 32'h20, 1, 0, 1, 0, 1);
        step("mis_clr", 3'd0, 32'h0,  0, 32'h20, 1, 0, 1, 0, 0);
        step("seti33",  3'd3, 32'h33, 0, 32'h20, 1, 0, 1, 0, 1);
        step("call_mis", 3'd5, 32'h2, 0, 32'h20, 1, 0, 1, 0, 1);
        step("mis_clr2", 3'd0, 32'h0, 0, 32'h20, 1, 0, 1, 0, 0);

        // Asynchronous reset mid-cycle at PC=0x40 with a non-empty stack
        step("calli40", 3'd6, 32'h41, 0, 32'h40, 0, 0, 1, 0, 0);
        @(negedge clk);
        pc_op = 3'd1;
        #2;
        reset = 1'b0;
        #1;
        expect_s("async_rst", 32'h0, 1, 0, 0, 0, 0);
        check_out();
        @(posedge clk);
        #1;
        expect_s("rst_hold", 32'h0, 1, 0, 0, 0, 0);
        check_out();
        @(negedge clk);
        reset = 1'b1;

        // Wrap-around, trap and clear vectors
        step("seti_top", 3'd3, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
        step("wrap",     3'd1, 32'h0, 0, 32'h0,   1, 0, 0, 0, 0);
        step("trap",     3'd4, 32'h1, 0, 32'h100, 1, 0, 0, 0, 0);
        step("clear",    3'd4, 32'h0, 0, 32'h0,   1, 0, 0, 0, 0);
        step("trap3",    3'd4, 32'h3, 0, 32'h100, 1, 0, 0, 0, 0);

        // Enable low: hold
        @(negedge clk);
        pc_write_enable = 1'b0;
        pc_op           = 3'd1;
        expect_s("we_low", 32'h100, 1, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_out();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
